// File: rtl/ram_arbiter_if.sv
// Request/grant/response bundle for the loader, fetch and data ports plus the single RAM port.
// The slave modport is the arbiter's view; master is the surrounding system.
interface ram_arbiter_if #(
  parameter int MEM_AW = 14
);
  logic              ld_req;
  logic [31:0]       ld_addr;
  logic [31:0]       ld_wdata;
  logic              ld_gnt;
  logic              ld_done;

  logic              instr_req;
  logic [31:0]       instr_addr;
  logic              instr_gnt;
  logic              instr_rvalid;
  logic [31:0]       instr_rdata;

  logic              data_req;
  logic              data_we;
  logic [3:0]        data_be;
  logic [31:0]       data_addr;
  logic [31:0]       data_wdata;
  logic              data_gnt;
  logic              data_rvalid;
  logic [31:0]       data_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  ld_req, ld_addr, ld_wdata, ld_done,
    output ld_gnt,
    input  instr_req, instr_addr,
    output instr_gnt, instr_rvalid, instr_rdata,
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output ld_req, ld_addr, ld_wdata, ld_done,
    input  ld_gnt,
    output instr_req, instr_addr,
    input  instr_gnt, instr_rvalid, instr_rdata,
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Boot sequencer + round-robin arbiter sharing one RAM port among loader, fetch and data.
// Grants are combinational (0-cycle accept), read data returns 1 cycle after grant; losers simply stay pending.
module ram_arbiter #(
  parameter int MEM_AW    = 14,
  parameter bit BOOT_LOAD = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             core_rst_n,
  ram_arbiter_if.slave     bus
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;
  typedef enum logic {OWN_INSTR = 1'b0, OWN_DATA = 1'b1} owner_t;

  localparam state_t RST_STATE = BOOT_LOAD ? BOOT : RUN;

  state_t state, state_nxt;
  owner_t rr, rsp_owner;
  logic   rsp_valid;

  logic   ld_gnt, instr_gnt, data_gnt;
  logic   instr_rvalid, data_rvalid;

  // Grants are forced low while rst_n is asserted, independent of the current state.
  always_comb begin
    state_nxt = state;
    ld_gnt    = 1'b0;
    instr_gnt = 1'b0;
    data_gnt  = 1'b0;
    if (rst_n) begin
      case (state)
        BOOT: begin
          ld_gnt = bus.ld_req;
          if (bus.ld_done) state_nxt = RUN;
        end
        RUN: begin
          instr_gnt = bus.instr_req && (!bus.data_req  || rr == OWN_DATA);
          data_gnt  = bus.data_req  && (!bus.instr_req || rr == OWN_INSTR);
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_be    = 4'h0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (ld_gnt) begin
      bus.mem_we    = 1'b1;
      bus.mem_be    = 4'hF;
      bus.mem_addr  = bus.ld_addr[MEM_AW+1:2];
      bus.mem_wdata = bus.ld_wdata;
    end else if (instr_gnt) begin
      bus.mem_be    = 4'hF;
      bus.mem_addr  = bus.instr_addr[MEM_AW+1:2];
    end else if (data_gnt) begin
      bus.mem_we    = bus.data_we;
      bus.mem_be    = bus.data_be;
      bus.mem_addr  = bus.data_addr[MEM_AW+1:2];
      bus.mem_wdata = bus.data_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RST_STATE;
      core_rst_n <= (RST_STATE == RUN);
      rr         <= OWN_DATA;
      rsp_valid  <= 1'b0;
      rsp_owner  <= OWN_INSTR;
    end else begin
      state      <= state_nxt;
      core_rst_n <= (state_nxt == RUN);
      rsp_valid  <= instr_gnt || data_gnt;
      if (instr_gnt) begin
        rr        <= OWN_INSTR;
        rsp_owner <= OWN_INSTR;
      end else if (data_gnt) begin
        rr        <= OWN_DATA;
        rsp_owner <= OWN_DATA;
      end
    end
  end

  // A response still in flight when reset arrives is suppressed immediately, not one edge later.
  assign instr_rvalid = rst_n && rsp_valid && (rsp_owner == OWN_INSTR);
  assign data_rvalid  = rst_n && rsp_valid && (rsp_owner == OWN_DATA);

  assign bus.ld_gnt       = ld_gnt;
  assign bus.instr_gnt    = instr_gnt;
  assign bus.data_gnt     = data_gnt;
  assign bus.mem_en       = ld_gnt || instr_gnt || data_gnt;
  assign bus.instr_rvalid = instr_rvalid;
  assign bus.data_rvalid  = data_rvalid;
  assign bus.instr_rdata  = instr_rvalid ? bus.mem_rdata : 32'h0;
  assign bus.data_rdata   = data_rvalid  ? bus.mem_rdata : 32'h0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.ld_addr[31:MEM_AW+2], bus.ld_addr[1:0],
                              bus.instr_addr[31:MEM_AW+2], bus.instr_addr[1:0],
                              bus.data_addr[31:MEM_AW+2], bus.data_addr[1:0]};

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, shadow-memory reference model and directed + random scenarios.
module tb_ram_arbiter;
  localparam int AW        = 14;
  localparam int RAM_WORDS = 1 << AW;
  localparam int LAST_I    = 0;
  localparam int LAST_D    = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic core_rst_n;
  logic clear_ram = 1'b0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  ram_arbiter_if #(.MEM_AW(AW)) bus();

  ram_arbiter #(.MEM_AW(AW), .BOOT_LOAD(1'b1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .core_rst_n(core_rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with 1-cycle read latency.
  logic [31:0] ram [0:RAM_WORDS-1];
  logic [31:0] ram_q;
  always @(posedge clk) begin
    if (clear_ram) begin
      for (int i = 0; i < RAM_WORDS; i++) ram[i] <= '0;
      ram_q <= '0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        ram_q <= ram[bus.mem_addr];
      end
    end
  end
  assign bus.mem_rdata = ram_q;

  // Reference: shadow memory contents and the last arbitration winner.
  logic [31:0] ref_mem [0:RAM_WORDS-1];
  int ref_last;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[AW+1:2] = AW'($urandom_range(0, 31));
    a[1:0] = 2'b00;
    return a;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  task automatic idle_inputs();
    bus.ld_req = 0; bus.ld_addr = 0; bus.ld_wdata = 0; bus.ld_done = 0;
    bus.instr_req = 0; bus.instr_addr = 0;
    bus.data_req = 0; bus.data_we = 0; bus.data_be = 0; bus.data_addr = 0; bus.data_wdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    clear_ram = 1;
    bus.ld_req = 1; bus.instr_req = 1; bus.data_req = 1;
    repeat (2) @(negedge clk);
    clear_ram = 0;
    #1;
    vectors++;
    if ({core_rst_n, bus.ld_gnt, bus.instr_gnt, bus.data_gnt, bus.mem_en} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {core_rst_n, bus.ld_gnt, bus.instr_gnt, bus.data_gnt, bus.mem_en});
    end
    vectors++;
    if ({bus.instr_rvalid, bus.data_rvalid, bus.instr_rdata, bus.data_rdata} !== 66'h0) begin
      miscompares++;
      $display("FAIL reset_rsp: rvalid %b%b rdata %h %h want all zero",
               bus.instr_rvalid, bus.data_rvalid, bus.instr_rdata, bus.data_rdata);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
    for (int i = 0; i < RAM_WORDS; i++) ref_mem[i] = '0;
    ref_last = LAST_D;
  endtask

  task automatic test_boot_blocked();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.instr_req = 1; bus.data_req = 1;
      bus.instr_addr = 32'h4; bus.data_addr = 32'h8;
      #1;
      vectors++;
      if ({bus.instr_gnt, bus.data_gnt, bus.mem_en, core_rst_n} !== 4'b0) begin
        miscompares++;
        $display("FAIL boot_blocked[%0d]: gnt/en/core_rst_n got %b want 0000", c,
                 {bus.instr_gnt, bus.data_gnt, bus.mem_en, core_rst_n});
      end
    end
    idle_inputs();
  endtask

  task automatic test_boot_load();
    logic [31:0] wd [3];
    logic [52:0] exp_v;
    wd[0] = 32'h00000013; wd[1] = 32'h00100093; wd[2] = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.ld_req = 1; bus.ld_addr = 32'(i * 4); bus.ld_wdata = wd[i];
      #1;
      exp_v = {1'b1, 1'b1, 1'b1, 4'hF, AW'(i), wd[i]};
      vectors++;
      if ({bus.ld_gnt, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== exp_v) begin
        miscompares++;
        $display("FAIL boot_load[%0d]: got gnt=%b en=%b we=%b be=%h addr=%0d wd=%h want 1 1 1 f %0d %h",
                 i, bus.ld_gnt, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata, i, wd[i]);
      end
      ref_mem[i] = wd[i];
    end
    @(negedge clk);
    idle_inputs();
    bus.ld_done = 1;
    #1;
    vectors++;
    if ({core_rst_n, bus.instr_rvalid, bus.data_rvalid} !== 3'b000) begin
      miscompares++;
      $display("FAIL boot_done_cycle: core_rst_n/rvalid got %b want 000",
               {core_rst_n, bus.instr_rvalid, bus.data_rvalid});
    end
    @(negedge clk);
    bus.ld_done = 0;
    #1;
    vectors++;
    if (core_rst_n !== 1'b1) begin
      miscompares++;
      $display("FAIL core_release: core_rst_n got %b want 1", core_rst_n);
    end
  endtask

  task automatic test_tie();
    logic [1:0]  exp_gnt;
    logic [65:0] exp_rsp;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.instr_req = (c < 4); bus.instr_addr = 32'h4;
      bus.data_req  = (c < 4); bus.data_addr  = 32'h0; bus.data_we = 0; bus.data_be = 4'hF;
      #1;
      exp_gnt = (c == 4) ? 2'b00 : ((c % 2 == 0) ? 2'b10 : 2'b01);
      vectors++;
      if ({bus.instr_gnt, bus.data_gnt} !== exp_gnt) begin
        miscompares++;
        $display("FAIL tie_gnt[%0d]: got %b want %b", c, {bus.instr_gnt, bus.data_gnt}, exp_gnt);
      end
      if (c == 0)          exp_rsp = 66'h0;
      else if (c % 2 == 1) exp_rsp = {1'b1, 1'b0, ref_mem[1], 32'h0};
      else                 exp_rsp = {1'b0, 1'b1, 32'h0, ref_mem[0]};
      vectors++;
      if ({bus.instr_rvalid, bus.data_rvalid, bus.instr_rdata, bus.data_rdata} !== exp_rsp) begin
        miscompares++;
        $display("FAIL tie_rsp[%0d]: got %b%b %h %h want %h", c, bus.instr_rvalid, bus.data_rvalid,
                 bus.instr_rdata, bus.data_rdata, exp_rsp);
      end
    end
    ref_last = LAST_D;
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_rd [3];
    exp_rd[0] = 32'h00000013; exp_rd[1] = 32'h00100093; exp_rd[2] = 32'hDEADBEEF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.instr_req = (c < 3); bus.instr_addr = 32'(c * 4);
      #1;
      vectors++;
      if ({bus.instr_gnt, bus.mem_en} !== {(c < 3), (c < 3)}) begin
        miscompares++;
        $display("FAIL b2b_gnt[%0d]: got %b%b want %b%b", c, bus.instr_gnt, bus.mem_en, c < 3, c < 3);
      end
      if (c > 0) begin
        vectors++;
        if ({bus.instr_rvalid, bus.instr_rdata} !== {1'b1, exp_rd[c-1]}) begin
          miscompares++;
          $display("FAIL b2b_rdata[%0d]: got v=%b %h want v=1 %h", c, bus.instr_rvalid,
                   bus.instr_rdata, exp_rd[c-1]);
        end
      end
    end
    ref_last = LAST_I;
    idle_inputs();
  endtask

  task automatic test_data_write_read();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.data_req = (c < 2); bus.data_addr = 32'h8;
      bus.data_we = (c == 0); bus.data_be = (c == 0) ? 4'b0011 : 4'hF;
      bus.data_wdata = 32'h12345678;
      #1;
      if (c < 2) begin
        vectors++;
        if ({bus.data_gnt, bus.mem_we, bus.mem_be} !== {1'b1, c == 0, (c == 0) ? 4'b0011 : 4'hF}) begin
          miscompares++;
          $display("FAIL wr_rd_gnt[%0d]: got gnt=%b we=%b be=%b", c, bus.data_gnt, bus.mem_we, bus.mem_be);
        end
      end
      if (c == 1) begin
        vectors++;
        if (bus.data_rvalid !== 1'b1) begin
          miscompares++;
          $display("FAIL write_rvalid: got %b want 1", bus.data_rvalid);
        end
      end
      if (c == 2) begin
        vectors++;
        if ({bus.data_rvalid, bus.data_rdata} !== {1'b1, 32'hDEAD5678}) begin
          miscompares++;
          $display("FAIL read_after_write: got v=%b %h want v=1 dead5678", bus.data_rvalid, bus.data_rdata);
        end
      end
    end
    ref_mem[2] = merge(ref_mem[2], 32'h12345678, 4'b0011);
    ref_last = LAST_D;
    idle_inputs();
  endtask

  task automatic test_random(input int n);
    bit pi = 0, pd = 0;
    logic [31:0] ia = 0, da = 0, dw = 0, wa;
    logic dwe = 0;
    logic [3:0] dbe = 0;
    int win;
    bit prev_v = 0;
    int prev_own = 0;
    logic prev_we = 0;
    logic [31:0] prev_rd = 0;
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      if (c == n) begin
        pi = 0; pd = 0;
      end else begin
        if (!pi && $urandom_range(0, 3) != 0) begin pi = 1; ia = rand_addr(); end
        if (!pd && $urandom_range(0, 2) != 0) begin
          pd = 1; da = rand_addr(); dwe = 1'($urandom_range(0, 1));
          dbe = 4'($urandom_range(0, 15)); dw = $urandom;
        end
      end
      bus.instr_req = pi; bus.instr_addr = ia;
      bus.data_req = pd; bus.data_addr = da; bus.data_we = dwe; bus.data_be = dbe; bus.data_wdata = dw;
      #1;
      if (pi && pd) win = (ref_last == LAST_D) ? 1 : 2;
      else if (pi)  win = 1;
      else if (pd)  win = 2;
      else          win = 0;
      vectors++;
      if ({bus.instr_gnt, bus.data_gnt, bus.mem_en} !== {win == 1, win == 2, win != 0}) begin
        miscompares++;
        $display("FAIL rand_gnt[%0d]: got %b want %b", c, {bus.instr_gnt, bus.data_gnt, bus.mem_en},
                 {win == 1, win == 2, win != 0});
      end
      if (win != 0) begin
        wa = (win == 1) ? ia : da;
        vectors++;
        if ({bus.mem_addr, bus.mem_we} !== {wa[AW+1:2], (win == 2) && dwe}) begin
          miscompares++;
          $display("FAIL rand_mem[%0d]: got addr=%0d we=%b want addr=%0d we=%b", c, bus.mem_addr,
                   bus.mem_we, wa[AW+1:2], (win == 2) && dwe);
        end
      end
      vectors++;
      if ({bus.instr_rvalid, bus.data_rvalid} !== {prev_v && prev_own == 1, prev_v && prev_own == 2}) begin
        miscompares++;
        $display("FAIL rand_rvalid[%0d]: got %b%b want %b%b", c, bus.instr_rvalid, bus.data_rvalid,
                 prev_v && prev_own == 1, prev_v && prev_own == 2);
      end
      if (prev_v && prev_own == 2 && prev_we) begin
        vectors++;
        if (bus.instr_rdata !== 32'h0) begin
          miscompares++;
          $display("FAIL rand_idle_rdata[%0d]: instr_rdata got %h want 0", c, bus.instr_rdata);
        end
      end else begin
        vectors++;
        if ({bus.instr_rdata, bus.data_rdata} !==
            {(prev_v && prev_own == 1) ? prev_rd : 32'h0, (prev_v && prev_own == 2) ? prev_rd : 32'h0}) begin
          miscompares++;
          $display("FAIL rand_rdata[%0d]: got %h %h expected word %h owner %0d", c, bus.instr_rdata,
                   bus.data_rdata, prev_rd, prev_v ? prev_own : 0);
        end
      end
      prev_v = (win != 0);
      prev_own = win;
      prev_we = 0;
      if (win == 1) begin
        prev_rd = ref_mem[widx(ia)];
        ref_last = LAST_I;
        pi = 0;
      end else if (win == 2) begin
        prev_we = dwe;
        if (dwe) ref_mem[widx(da)] = merge(ref_mem[widx(da)], dw, dbe);
        else     prev_rd = ref_mem[widx(da)];
        ref_last = LAST_D;
        pd = 0;
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    bus.instr_req = 1; bus.instr_addr = 32'h4;
    #1;
    vectors++;
    if (bus.instr_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL midop_fetch_gnt: got %b want 1", bus.instr_gnt);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    #1;
    vectors++;
    if ({bus.instr_rvalid, bus.data_rvalid} !== 2'b00) begin
      miscompares++;
      $display("FAIL midop_rvalid_in_reset: got %b%b want 00", bus.instr_rvalid, bus.data_rvalid);
    end
    @(negedge clk);
    #1;
    vectors++;
    if ({core_rst_n, bus.instr_rvalid} !== 2'b00) begin
      miscompares++;
      $display("FAIL midop_after_edge: core_rst_n/instr_rvalid got %b%b want 00", core_rst_n, bus.instr_rvalid);
    end
    rst_n = 1;
    ref_last = LAST_D;
    @(negedge clk);
    #1;
    vectors++;
    if ({core_rst_n, bus.instr_rvalid} !== 2'b00) begin
      miscompares++;
      $display("FAIL midop_released: core_rst_n/instr_rvalid got %b%b want 00", core_rst_n, bus.instr_rvalid);
    end
    @(negedge clk);
    bus.ld_done = 1;
    @(negedge clk);
    idle_inputs();
    bus.instr_req = 1; bus.instr_addr = 32'h4;
    bus.data_req = 1; bus.data_addr = 32'h0; bus.data_be = 4'hF;
    #1;
    vectors++;
    if ({core_rst_n, bus.instr_gnt, bus.data_gnt} !== 3'b110) begin
      miscompares++;
      $display("FAIL midop_first_tie: core_rst_n/instr_gnt/data_gnt got %b want 110",
               {core_rst_n, bus.instr_gnt, bus.data_gnt});
    end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if ({bus.instr_rvalid, bus.instr_rdata} !== {1'b1, ref_mem[1]}) begin
      miscompares++;
      $display("FAIL midop_tie_rdata: got v=%b %h want v=1 %h", bus.instr_rvalid, bus.instr_rdata, ref_mem[1]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_boot_blocked();
    test_boot_load();
    test_tie();
    test_back_to_back();
    test_data_write_read();
    test_random(400);
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Boot sequencer and round-robin arbiter that shares the single-port program/data RAM between three requesters: the firmware loader, the core instruction-fetch port and the core data port. It sits between `riscv_core` and the RAM inside `riscv_top`. It holds the core in reset while firmware is written through the loader port, then releases the core and arbitrates its fetch and data traffic onto the one RAM port.

## Interface
- `MEM_AW`, 14: RAM word-address width; the RAM holds 2^MEM_AW 32-bit words.
- `BOOT_LOAD`, 1: 1 = start in BOOT and wait for the loader; 0 = start directly in RUN.

- `clk` in 1: clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `core_rst_n` out 1: reset to `riscv_core`; low in BOOT, high in RUN.
- `ld_req` in 1: loader write request.
- `ld_addr` in 32: loader byte address; must be word aligned.
- `ld_wdata` in 32: loader write data.
- `ld_gnt` out 1: loader request accepted this cycle.
- `ld_done` in 1: one-cycle pulse; loading is complete.
- `instr_req` in 1: fetch request.
- `instr_addr` in 32: fetch byte address.
- `instr_gnt` out 1: fetch accepted.
- `instr_rvalid` out 1: fetch data valid.
- `instr_rdata` out 32: fetch data.
- `data_req` in 1: data request.
- `data_we` in 1: 1 = write.
- `data_be` in 4: byte enables.
- `data_addr` in 32: data byte address.
- `data_wdata` in 32: write data.
- `data_gnt` out 1: data request accepted.
- `data_rvalid` out 1: data response; also asserted for writes.
- `data_rdata` out 32: read data.
- `mem_en` out 1: RAM access strobe.
- `mem_we` out 1: RAM write.
- `mem_be` out 4: RAM byte enables.
- `mem_addr` out MEM_AW: RAM word address, taken from byte address bits [MEM_AW+1:2].
- `mem_wdata` out 32: RAM write data.
- `mem_rdata` in 32: RAM read data, valid one cycle after `mem_en`.

## Operation
- States: BOOT, RUN. Reset state is BOOT if BOOT_LOAD=1, otherwise RUN.
  - BOOT -> RUN when `ld_done`=1.
  - There is no other transition; RUN is left only through reset.
- BOOT:
  - `core_rst_n`=0.
  - Only the loader is served: `ld_gnt`=`ld_req`, with mem_we=1 and mem_be=4'hF.
  - `instr_gnt`=0 and `data_gnt`=0 regardless of requests.
  - No rvalid is generated for loader writes.
  - If `ld_req` and `ld_done` are high in the same cycle, the write is granted and the state then moves to RUN.
- RUN:
  - `ld_gnt`=0; loader inputs are ignored.
  - Single requester: granted in the same cycle.
  - Both `instr_req` and `data_req` high: round-robin. Register `rr` records the last winner.
    - The side that did not win last is granted.
    - `rr` updates on every instr or data grant, including uncontended grants.
  - Reset value of `rr` = data, so instr wins the first tie.
  - At most one grant per cycle. `mem_en` equals the OR of all grants.
  - `mem_*` fields are muxed combinationally from the granted port. Fetch drives mem_we=0.
  - When no port is granted, `mem_we`, `mem_be`, `mem_addr` and `mem_wdata` are 0.
- Response path:
  - Registers `rsp_valid` and `rsp_owner` (instr/data) are loaded on every RUN grant.
  - In the following cycle, the owner's rvalid=1 and its rdata=`mem_rdata`.
  - The non-owner's rdata is 0.
  - A data write also produces `data_rvalid`; `data_rdata` is don't-care for writes.
- Requesters hold `req` and their address/data stable until `gnt`. A request that is not granted stays pending with no side effect.
- Address bits above MEM_AW+1 are ignored, so addresses wrap modulo the RAM size.

## Timing
- Grant is combinational from `req` and state: 0-cycle acceptance.
- Read latency is 1 cycle from grant to rvalid. One access per cycle sustained, back-to-back, with no bubbles.
- `core_rst_n` is registered. It rises in the cycle after the clock edge on which `ld_done` is sampled.
- Reset values:
  - `core_rst_n` = 0 if BOOT_LOAD=1, 1 if BOOT_LOAD=0.
  - `instr_rvalid`, `data_rvalid`, `rsp_valid` = 0.
  - `rr` = data; state per BOOT_LOAD.
  - All rdata outputs = 0.
- Reset during operation:
  - Any in-flight response is dropped; no rvalid appears after reset.
  - The state returns to BOOT and `core_rst_n` drops on the same reset edge.
- The grant outputs are combinational, so they are 0 during reset.

## Test plan
- **Boot load, BOOT_LOAD=1.**
  - Stimulus: loader writes 32'h00000013 to 0x0, 32'h00100093 to 0x4 and 32'hDEADBEEF to 0x8, then pulses `ld_done`.
  - Required: each loader write gets `ld_gnt` in the same cycle, with mem_we=1 and mem_addr 0, 1, 2.
  - Required: `core_rst_n` is high one cycle after `ld_done`.
- **Requests blocked in BOOT.**
  - Stimulus: `instr_req`=`data_req`=1 for 5 cycles while in BOOT.
  - Required: `instr_gnt`, `data_gnt` and `mem_en` stay 0 throughout.
- **Tie alternation.**
  - Stimulus: in RUN, hold both requests for 4 cycles.
  - Required: grants go instr, data, instr, data.
  - Required: rvalid follows each grant one cycle later on the matching port, with rdata equal to the RAM word.
- **Back-to-back single requester.**
  - Stimulus: fetch from 0x0, 0x4, 0x8 on consecutive cycles.
  - Required: a grant every cycle, and `instr_rdata` returns 0x00000013, 0x00100093, 0xDEADBEEF on consecutive cycles.
- **Data write then read.**
  - Stimulus: write be=4'b0011, data 32'h12345678 to 0x8, then read 0x8.
  - Required: `data_rvalid` is returned for the write, and the read returns 32'hDEAD5678.
- **Reset during operation.**
  - Stimulus: assert `rst_n`=0 in the cycle after a fetch grant.
  - Required: `instr_rvalid` stays 0 and `core_rst_n`=0.
  - Required: after reset, the first tie is granted to instr.
